// File: rtl/cfg_xform_pkg.sv
// Shared definitions for the configurable stream transform block: register
// offsets, CTRL bit positions and the frame state encoding.
package cfg_xform_pkg;

  localparam logic [15:0] REG_CTRL     = 16'd0;
  localparam logic [15:0] REG_MASK     = 16'd1;
  localparam logic [15:0] REG_FRM_CNT  = 16'd2;
  localparam logic [15:0] REG_BYTE_CNT = 16'd3;
  localparam logic [15:0] REG_STATUS   = 16'd4;

  localparam int unsigned CTRL_INV_BIT = 0;
  localparam int unsigned CTRL_XOR_BIT = 1;

  typedef enum logic {
    IDLE,
    FRAME
  } xf_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear in the same cycle as an increment wins.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cfg_xform_dp.sv
// Bus-configured stream transform: optional invert then XOR mask, one cycle of
// latency, with config captured only at frame start plus frame/beat counters.
module cfg_xform_dp
  import cfg_xform_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter logic [15:0] BASE_ADDR = 16'h9,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_cmd_valid,
  input  logic              bus_op,
  input  logic [15:0]       bus_addr,
  input  logic [15:0]       bus_wr_data,
  output logic [15:0]       bus_rd_data,
  input  logic [DATA_W-1:0] rxd,
  input  logic              rx_dv,
  output logic [DATA_W-1:0] txd,
  output logic              tx_en
);

  xf_state_e         state_q, state_d;
  logic              ctrl_inv_q, ctrl_xor_q;
  logic [DATA_W-1:0] mask_q;
  logic              act_inv_q, act_xor_q;
  logic [DATA_W-1:0] act_mask_q;
  logic [DATA_W-1:0] txd_q, txd_d;
  logic              tx_en_q;
  logic [15:0]       rd_data_q, rd_mux;

  logic              wr_en, rd_en, frame_start;
  logic [15:0]       offset;
  logic              cur_inv, cur_xor;
  logic [DATA_W-1:0] cur_mask;
  logic              cfg_pending;
  logic [CNT_W-1:0]  frm_cnt, byte_cnt;
  logic              frm_clr, byte_clr;
  logic              unused_wdata;

  assign wr_en       = bus_cmd_valid && bus_op;
  assign rd_en       = bus_cmd_valid && !bus_op;
  assign offset      = bus_addr - BASE_ADDR;
  assign frame_start = (state_q == IDLE) && rx_dv;
  assign frm_clr     = wr_en && (offset == REG_FRM_CNT);
  assign byte_clr    = wr_en && (offset == REG_BYTE_CNT);
  assign unused_wdata = ^bus_wr_data;

  assign cfg_pending = (ctrl_inv_q != act_inv_q) || (ctrl_xor_q != act_xor_q) ||
                       (mask_q != act_mask_q);

  // The first beat of a frame uses the shadow config being captured this cycle.
  always_comb begin
    cur_inv  = frame_start ? ctrl_inv_q : act_inv_q;
    cur_xor  = frame_start ? ctrl_xor_q : act_xor_q;
    cur_mask = frame_start ? mask_q     : act_mask_q;
    txd_d    = rxd;
    if (cur_inv) txd_d = ~txd_d;
    if (cur_xor) txd_d = txd_d ^ cur_mask;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rx_dv)  state_d = FRAME;
      FRAME:   if (!rx_dv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (offset)
      REG_CTRL: begin
        rd_mux[CTRL_INV_BIT] = ctrl_inv_q;
        rd_mux[CTRL_XOR_BIT] = ctrl_xor_q;
      end
      REG_MASK:     rd_mux[DATA_W-1:0] = mask_q;
      REG_FRM_CNT:  rd_mux[CNT_W-1:0]  = frm_cnt;
      REG_BYTE_CNT: rd_mux[CNT_W-1:0]  = byte_cnt;
      REG_STATUS:   rd_mux[1:0]        = {cfg_pending, state_q == FRAME};
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ctrl_inv_q <= 1'b0;
      ctrl_xor_q <= 1'b0;
      mask_q     <= '0;
      act_inv_q  <= 1'b0;
      act_xor_q  <= 1'b0;
      act_mask_q <= '0;
      txd_q      <= '0;
      tx_en_q    <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      tx_en_q <= rx_dv;
      if (frame_start) begin
        act_inv_q  <= ctrl_inv_q;
        act_xor_q  <= ctrl_xor_q;
        act_mask_q <= mask_q;
      end
      if (wr_en && (offset == REG_CTRL)) begin
        ctrl_inv_q <= bus_wr_data[CTRL_INV_BIT];
        ctrl_xor_q <= bus_wr_data[CTRL_XOR_BIT];
      end
      if (wr_en && (offset == REG_MASK)) begin
        mask_q <= bus_wr_data[DATA_W-1:0];
      end
      if (rd_en) begin
        rd_data_q <= rd_mux;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_frm_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_start),
    .clr   (frm_clr),
    .cnt   (frm_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_byte_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rx_dv),
    .clr   (byte_clr),
    .cnt   (byte_cnt)
  );

  assign txd         = txd_q;
  assign tx_en       = tx_en_q;
  assign bus_rd_data = rd_data_q;

endmodule

// File: doc/cfg_xform_dp.md
# cfg_xform_dp

Parametrised, bus-configured byte-stream transform block: the successor of the single-bit invert datapath. It passes an rx stream (`rxd`/`rx_dv`) to a tx stream (`txd`/`tx_en`) with one cycle of latency, applying an optional invert and XOR mask. Configuration is shadowed and captured only at frame start, so changes never apply mid-frame. It sits on the same 16-bit register bus and adds frame and byte statistics counters readable for register-model checks.

## Interface
- `DATA_W`, 8: stream width, legal range 1..16.
- `BASE_ADDR`, 16'h9: bus address of register 0. Registers occupy `BASE_ADDR`..`BASE_ADDR`+4.
- `CNT_W`, 16: statistics counter width, legal range 1..16.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `bus_cmd_valid` in 1: bus command strobe.
- `bus_op` in 1: 1 = write, 0 = read.
- `bus_addr` in 16: register address.
- `bus_wr_data` in 16: write data.
- `bus_rd_data` out 16: registered read data.
- `rxd` in `DATA_W`: input data.
- `rx_dv` in 1: input valid; a frame is a contiguous run of `rx_dv` = 1.
- `txd` out `DATA_W`: transformed data.
- `tx_en` out 1: output valid.

## Operation
Register map (offset from `BASE_ADDR`); unmapped reads return 0 and unmapped writes are ignored:
- +0 CTRL, RW: bit0 `invert`, bit1 `xor_en`, other bits read 0.
- +1 XOR_MASK, RW: bits [`DATA_W`-1:0]; upper bits read 0.
- +2 FRM_CNT, RO: number of frame starts; saturates at all-ones; any write clears it.
- +3 BYTE_CNT, RO: number of beats with `rx_dv` = 1; saturates; any write clears it.
- +4 STATUS, RO: bit0 `in_frame` (state == FRAME), bit1 `cfg_pending` (shadow differs from active).

Config path:
- Bus writes update the shadow CTRL and MASK registers.
- The active config (`act_inv`, `act_xor`, `act_mask`) is loaded from the shadow registers only on the IDLE->FRAME transition.

State machine, two states:
- IDLE: on `rx_dv` = 1, go to FRAME, load the active config, and increment FRM_CNT.
- FRAME: on `rx_dv` = 0, go to IDLE.

Transform, using the active config; the first beat of a frame uses the config being loaded that cycle:
- d = `rxd`
- if invert: d = ~d
- if xor_en: d = d ^ mask
- order is fixed: invert, then XOR.

Boundary rules:
- A CTRL/MASK write in the same cycle as a frame start: the frame uses the pre-write shadow value.
- A counter clear write in the same cycle as an increment: the clear wins, and the counter reads 0.
- A read of a register in the same cycle as its update returns the pre-update value.
- Counters hold at all-ones once saturated and never wrap.
- Reset mid-frame: everything returns to reset values next cycle and the state is IDLE. A frame still active after reset release counts as a new frame start.

## Timing
- Reset values:
  - `txd` = 0, `tx_en` = 0, `bus_rd_data` = 0.
  - CTRL, MASK, active config, FRM_CNT and BYTE_CNT = 0; state = IDLE.
- Stream latency is 1 cycle: `txd`/`tx_en` at cycle n+1 reflect `rxd`/`rx_dv` at cycle n.
- When `rx_dv` = 0, `txd` still registers the transformed `rxd`, matching the previous generation.
- Write: takes effect at the edge where `bus_cmd_valid` && `bus_op`; visible to a read issued in the next cycle.
- Read: `bus_rd_data` is valid 1 cycle after `bus_cmd_valid` && !`bus_op`, and holds its value until the next read. There are no wait states and no back-pressure.

## Structure
- Package `cfg_xform_pkg`:
  - register offset localparams (`REG_CTRL`..`REG_STATUS`);
  - CTRL bit indices;
  - state typedef `xf_state_e` {IDLE, FRAME}.
- Sub-module `sat_counter` (params `W`; inputs `inc`, `clr`, with clear priority), instantiated for FRM_CNT and BYTE_CNT.

## Test plan
- Reset, then read offsets +0..+4 -> all return 0; `txd` = 0, `tx_en` = 0.
- Write CTRL = 1, then a 4-beat frame with `rxd` = 8'h0F -> `txd` = 8'hF0 for 4 cycles, 1 cycle after input; FRM_CNT = 1, BYTE_CNT = 4.
- Write MASK = 8'hA5 and CTRL = 3, then a frame with `rxd` = 8'h3C -> `txd` = ~8'h3C ^ 8'hA5 = 8'h66.
- Mid-frame write CTRL = 0 during an inverting frame -> the rest of the frame stays inverted and STATUS = 2'b11. The next frame passes data through unchanged.
- Set `CNT_W` = 4, run 20 one-beat frames -> FRM_CNT = 15 (saturated). Then write FRM_CNT in the same cycle as a frame start -> reads 0.
- Assert reset for 1 cycle mid-frame with `rx_dv` held high -> `tx_en` = 0 the next cycle, the config reverts to pass-through, and FRM_CNT = 1 after release.
